// File: rtl/seg_shift_out_if.sv
// Handshake bundle between the display controller and the serial output stage.
// The controller drives the master side; seg_shift_out sits on the slave side.
interface seg_shift_out_if #(
    parameter int WIDTH = 8
);
    logic             i_load;
    logic [WIDTH-1:0] i_data;
    logic             i_latch;
    logic             o_busy;
    logic             o_sclk;
    logic             o_sdata;
    logic             o_rclk;
    logic             o_done;
    logic             o_err;

    modport master (
        output i_load, i_data, i_latch,
        input  o_busy, o_sclk, o_sdata, o_rclk, o_done, o_err
    );

    modport slave (
        input  i_load, i_data, i_latch,
        output o_busy, o_sclk, o_sdata, o_rclk, o_done, o_err
    );
endinterface

// File: rtl/seg_shift_out.sv
// Serial output stage for a 74HC595-style display chain: shifts a loaded word out
// on a divided serial clock and turns latch requests into storage-clock pulses.
module seg_shift_out #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1,
    parameter int LATCH_LEN = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seg_shift_out_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, HIGH} state_t;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0]    LAT_LAST = 4'(LATCH_LEN - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       div_cnt;
    logic [3:0]       lat_cnt;
    logic             lat_pend;
    logic             busy, sclk, sdata, rclk, done, err;

    logic phase_end, last_bit, finishing, lat_acc, lat_fire;

    function automatic logic first_bit(input logic [WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? d[WIDTH-1] : d[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
        return (MSB_FIRST != 0) ? (d << 1) : (d >> 1);
    endfunction

    assign phase_end = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign finishing = (state == HIGH) && phase_end && last_bit;
    assign lat_acc   = bus.i_latch && !rclk && !lat_pend;
    // A latch requested mid-shift is held back until the edge where busy drops,
    // so the storage clock never captures a half-shifted chain.
    assign lat_fire  = (lat_acc && (!busy || finishing)) || (lat_pend && finishing);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            lat_cnt  <= '0;
            lat_pend <= 1'b0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            rclk     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_load) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        sclk    <= 1'b0;
                        sdata   <= first_bit(bus.i_data);
                        shreg   <= advance(bus.i_data);
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state   <= HIGH;
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (last_bit) begin
                            state <= IDLE;
                            sdata <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= SETUP;
                            sdata   <= first_bit(shreg);
                            shreg   <= advance(shreg);
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.i_load && busy)
                err <= 1'b1;

            if (lat_fire) begin
                rclk     <= 1'b1;
                lat_cnt  <= LAT_LAST;
                lat_pend <= 1'b0;
            end else begin
                if (lat_acc && busy)
                    lat_pend <= 1'b1;
                if (rclk) begin
                    if (lat_cnt == 4'd0)
                        rclk <= 1'b0;
                    else
                        lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

    assign bus.o_busy  = busy;
    assign bus.o_sclk  = sclk;
    assign bus.o_sdata = sdata;
    assign bus.o_rclk  = rclk;
    assign bus.o_done  = done;
    assign bus.o_err   = err;
endmodule

// File: tb/tb_seg_shift_out.sv
// Bench for seg_shift_out: table-driven shift vectors, hand-written latch/reset
// sequences and random traffic against a time-based reference model.
module tb_seg_shift_out;
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    seg_shift_out_if #(.WIDTH(8)) ifa ();
    seg_shift_out_if #(.WIDTH(8)) ifb ();

    seg_shift_out dut_a (.i_clk(i_clk), .i_rst(i_rst), .bus(ifa));
    seg_shift_out #(.CLK_DIV(1), .MSB_FIRST(0)) dut_b (.i_clk(i_clk), .i_rst(i_rst), .bus(ifb));

    // Reference model: state is "edge count", "edge a load was accepted",
    // "edge the storage clock rose"; outputs are derived by arithmetic on time.
    typedef struct {
        int         n;
        int         ld;
        logic [7:0] d;
        int         rise;
        logic       pend;
        logic       err;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t m_rst();
        mst_t s;
        s.n = 0; s.ld = -100000; s.d = 8'h00; s.rise = -100000; s.pend = 1'b0; s.err = 1'b0;
        return s;
    endfunction

    // {busy, sclk, sdata, rclk, done, err}
    function automatic logic [5:0] m_out(input mst_t s, input int D, input bit msb);
        int k, bi;
        logic bz, sc, sd, dn, rc;
        k  = s.n - s.ld;
        bz = (k >= 0) && (k < 16 * D);
        bi = k / (2 * D);
        sc = bz && ((k % (2 * D)) >= D);
        sd = 1'b0;
        if (bz) sd = msb ? s.d[7 - bi] : s.d[bi];
        dn = (k == 16 * D);
        rc = (s.n - s.rise >= 0) && (s.n - s.rise < 2);
        return {bz, sc, sd, rc, dn, s.err};
    endfunction

    function automatic mst_t m_step(input mst_t s, input logic ld, input logic [7:0] d,
                                    input logic lt, input int D, input bit msb);
        logic [5:0] p;
        logic ends, acc;
        p   = m_out(s, D, msb);
        s.n = s.n + 1;
        ends = p[5] && (s.n - s.ld == 16 * D);
        if (ld) begin
            if (p[5]) s.err = 1'b1;
            else begin s.ld = s.n; s.d = d; end
        end
        acc = lt && !p[2] && !s.pend;
        if (acc && (!p[5] || ends)) s.rise = s.n;
        else if (acc) s.pend = 1'b1;
        if (s.pend && ends) begin s.rise = s.n; s.pend = 1'b0; end
        return s;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ma <= m_rst();
            mb <= m_rst();
        end else begin
            ma <= m_step(ma, ifa.i_load, ifa.i_data, ifa.i_latch, 2, 1'b1);
            mb <= m_step(mb, ifb.i_load, ifb.i_data, ifb.i_latch, 1, 1'b0);
        end
    end

    function automatic logic [5:0] outs(input bit b);
        if (b) return {ifb.o_busy, ifb.o_sclk, ifb.o_sdata, ifb.o_rclk, ifb.o_done, ifb.o_err};
        return {ifa.o_busy, ifa.o_sclk, ifa.o_sdata, ifa.o_rclk, ifa.o_done, ifa.o_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("model_a", 32'(outs(1'b0)), 32'(m_out(ma, 2, 1'b1)));
            chk("model_b", 32'(outs(1'b1)), 32'(m_out(mb, 1, 1'b0)));
        end
    end

    task automatic set_in(input bit b, input logic l, input logic [7:0] d, input logic t);
        if (b) begin ifb.i_load = l; ifb.i_data = d; ifb.i_latch = t; end
        else   begin ifa.i_load = l; ifa.i_data = d; ifa.i_latch = t; end
    endtask

    // Load d at edge E0, optional extra load (data 00) and latches at E0+offset
    // (-1 = edge before E0). Observation j follows edge E0+j.
    task automatic run_vec(input bit b, input logic [7:0] d, input logic [7:0] exp_seq,
                           input int exp_busy, input int inj, input int lat1, input int lat2,
                           input int exp_rf, input int exp_rc);
        logic [5:0] o, po;
        logic [7:0] seq;
        int nb, nr, nd, dat, rf, rc;
        seq = 8'h00; nb = 0; nr = 0; nd = 0; dat = -99; rf = -99; rc = 0; po = 6'h0; o = 6'h0;
        set_in(b, 1'b0, 8'h00, lat1 == -1);
        @(negedge i_clk);
        for (int j = -1; j <= exp_busy + 4; j++) begin
            o = outs(b);
            if (o[5]) nb++;
            if (o[4] && !po[4]) begin seq = {seq[6:0], o[3]}; nr++; end
            if (o[1]) begin nd++; dat = j; end
            if (o[2]) begin if (rf == -99) rf = j; rc++; end
            po = o;
            set_in(b, (j == -1) || (j + 1 == inj), (j == -1) ? d : 8'h00,
                   (j + 1 == lat1) || (j + 1 == lat2));
            @(negedge i_clk);
        end
        chk("bit_seq",     32'(seq), 32'(exp_seq));
        chk("sclk_rises",  nr, 8);
        chk("busy_cycles", nb, exp_busy);
        chk("done_count",  nd, 1);
        chk("done_at",     dat, exp_busy);
        chk("rclk_first",  rf, exp_rf);
        chk("rclk_cycles", rc, exp_rc);
        chk("idle_lines",  32'(o[4:3]), 0);
    endtask

    typedef struct {
        bit         b;
        logic [7:0] d;
        logic [7:0] seq;
        int         busy;
        int         inj;
        int         lat1;
        int         lat2;
        int         rf;
        int         rc;
    } vec_t;

    vec_t vt[7];

    initial begin
        vt[0] = '{1'b0, 8'hA5, 8'hA5, 32, -99, -99, -99, -99, 0};
        vt[1] = '{1'b1, 8'h01, 8'h80, 16, -99, -99, -99, -99, 0};
        vt[2] = '{1'b1, 8'hB2, 8'h4D, 16, -99, -99, -99, -99, 0};
        vt[3] = '{1'b0, 8'hA5, 8'hA5, 32, -99, 10,  20,  32,  2};
        vt[4] = '{1'b0, 8'h5A, 8'h5A, 32, -99, 10,  33,  32,  2};
        vt[5] = '{1'b0, 8'h3C, 8'h3C, 32, -99, -1,  -99, -1,  2};
        vt[6] = '{1'b0, 8'hFF, 8'hFF, 32, 5,   -99, -99, -99, 0};

        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        #2 i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("reset_a", 32'(outs(1'b0)), 0);
        chk("reset_b", 32'(outs(1'b1)), 0);
        i_rst = 1'b0;
        chk_en = 1'b1;
        @(negedge i_clk);

        foreach (vt[i])
            run_vec(vt[i].b, vt[i].d, vt[i].seq, vt[i].busy, vt[i].inj,
                    vt[i].lat1, vt[i].lat2, vt[i].rf, vt[i].rc);

        // Error flag is sticky until reset.
        chk("err_set", 32'(ifa.o_err), 1);
        repeat (10) @(negedge i_clk);
        chk("err_held", 32'(ifa.o_err), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("err_cleared", 32'(ifa.o_err), 0);
        @(negedge i_clk);

        // Async reset mid-shift (bit 4) with a latch pending.
        set_in(1'b0, 1'b1, 8'hA5, 1'b0);
        @(negedge i_clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) @(negedge i_clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge i_clk);
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (11) @(negedge i_clk);
        chk("busy_before_rst", 32'(ifa.o_busy), 1);
        #2 i_rst = 1'b1;
        #1 chk("async_rst_a", 32'(outs(1'b0)), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run_vec(1'b0, 8'hA5, 8'hA5, 32, -99, -99, -99, -99, 0);

        // Random traffic; the model comparison runs every cycle.
        for (int c = 0; c < 800; c++) begin
            set_in(1'b0, $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 9) == 0);
            set_in(1'b1, $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 9) == 0);
            @(negedge i_clk);
        end
        set_in(1'b0, 1'b0, 8'h00, 1'b0);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (40) @(negedge i_clk);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_shift_out.md
Name: seg_shift_out

Overview:
- Serial output stage directly downstream of the display controller.
- Takes the mux-selected segment byte on a one-cycle load strobe and shifts it out MSB- or LSB-first on a divided serial clock. Reports busy back to the controller.
- Turns the controller's latch strobe into a storage-register clock pulse for the external 74HC595-style display shift chain.

Parameters:
WIDTH, 8, bits per load word
CLK_DIV, 2, system clocks per serial-clock half period (legal range 1..255)
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first
LATCH_LEN, 2, system clocks o_rclk stays high per latch (legal range 1..15)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_load  in  1  one-cycle strobe; capture i_data and start shifting
i_data  in  WIDTH  word to shift out, sampled only when i_load accepted
i_latch  in  1  one-cycle strobe; request an o_rclk pulse
o_busy  out  1  shift in progress (registered)
o_sclk  out  1  serial clock to shift chain (registered)
o_sdata  out  1  serial data (registered)
o_rclk  out  1  storage/latch clock to shift chain (registered)
o_done  out  1  one-cycle pulse when last bit finished
o_err  out  1  sticky: i_load arrived while busy

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Shift register, bit counter, divider counter, latch counter and latch-pending flag cleared.
- FSM states: IDLE, SETUP (o_sclk=0, bit on o_sdata), HIGH (o_sclk=1).
- IDLE + i_load=1 at edge E0:
  - At E0: i_data captured, o_busy=1, o_sdata=first bit, o_sclk=0, state to SETUP, bit count=0, div count=0.
  - o_busy must already be high the cycle after i_load.
  - The controller re-samples busy two cycles after loading.
- SETUP lasts CLK_DIV cycles, then goes to HIGH with o_sclk=1. o_sdata is held stable across the whole SETUP+HIGH pair.
- HIGH lasts CLK_DIV cycles. At its end:
  - If bit count < WIDTH-1: state to SETUP, o_sclk=0, o_sdata=next bit, bit count+1.
  - Otherwise: state to IDLE, o_sclk=0, o_sdata=0, o_busy=0, o_done=1 for exactly one cycle.
- Total busy time = 2*CLK_DIV*WIDTH cycles; o_busy falls at edge E0+2*CLK_DIV*WIDTH. Defaults give 32 cycles.
- Exactly WIDTH rising edges on o_sclk per load, no glitches.
- i_load while o_busy=1: ignored. The shift is unaffected and o_err is set, staying set until reset.
- i_load in the same cycle o_done is high: accepted as a normal IDLE load, since o_busy is already 0.
- Latch handling (independent of load):
  - i_latch while not busy and o_rclk=0: o_rclk=1 from the next edge for LATCH_LEN cycles, then 0.
  - i_latch while busy: latch-pending set. o_rclk rises on the edge where o_busy falls, same edge as o_done.
  - i_latch while o_rclk already high or pending already set: ignored. No extension, no stacking.
- i_latch and i_load together in IDLE: both accepted. o_rclk rises at E0 and the shift starts at E0. The first o_sclk rise is CLK_DIV cycles later, so the latch edge always precedes it.
- Controller sequence latch-then-load on the next cycle must work: the load is accepted while o_rclk is high.
- o_busy does not include latch time.
- The divider counter is sized for 255. The latch counter is sized for 15.

Test Plan:
1. Reset. Load 8'hA5 with defaults. Expect o_sdata bit sequence 1,0,1,0,0,1,0,1 sampled on 8 o_sclk rises. o_busy high exactly 32 cycles. o_done single pulse at cycle 32. Afterwards o_sclk=0, o_sdata=0.
2. MSB_FIRST=0, CLK_DIV=1, load 8'h01. Expect bit sequence 1,0,0,0,0,0,0,0. Busy 16 cycles.
3. Load 8'hFF, then pulse i_load with 8'h00 at cycle 5. Expect output still all ones, busy still ends at cycle 32, o_err=1 and held. Reset clears o_err.
4. Pulse i_latch at cycle 10 of a shift. Expect no o_rclk until o_busy falls. Then o_rclk high 2 cycles starting on the o_done edge. Second i_latch during pending: no extra pulse.
5. Idle: pulse i_latch, then i_load(8'h3C) next cycle. Expect o_rclk high 2 cycles, load accepted with o_busy=1 while o_rclk high, correct 8-bit output.
6. Assert i_rst asynchronously mid-shift (between clock edges, bit 4). Expect all outputs 0 immediately and pending latch dropped. A subsequent load behaves as in scenario 1.
